// File: rtl/core_dmem_if.sv
// Load/store request and response channel between the MEM stage (master) and core_dmem (slave).
`ifndef CPU_XLEN
`define CPU_XLEN 32
`endif

interface core_dmem_if;
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_we_i;
    logic [`CPU_XLEN-1:0] req_addr_i;
    logic [`CPU_XLEN-1:0] req_wdata_i;
    logic [1:0]           req_size_i;
    logic                 req_unsigned_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [`CPU_XLEN-1:0] rsp_rdata_o;
    logic                 rsp_err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/core_dmem.sv
// Single-cycle-latency data memory with byte-lane stores and sign/zero-extended loads.
// Define CORE_DMEM_ERR_CHK_EN to fault misaligned, reserved-size and out-of-range accesses.
`ifndef CPU_XLEN
`define CPU_XLEN 32
`endif

module core_dmem #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    core_dmem_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int XLEN  = `CPU_XLEN;

    logic                  rsp_valid_reg;
    logic                  rsp_err_reg;
    logic                  rsp_load_reg;
    logic [1:0]            rsp_size_reg;
    logic [1:0]            rsp_lane_reg;
    logic                  rsp_unsigned_reg;

    logic                  accept;
    logic                  fault;
    logic [1:0]            eff_size;
    logic [1:0]            lane;
    logic [3:0]            be;
    logic [31:0]           wdata_lanes;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           rd_word;
    logic [31:0]           shifted;
    logic [XLEN-1:0]       load_data;

    assign bus.req_ready_o = !rsp_valid_reg || bus.rsp_ready_i;
    assign accept          = bus.req_valid_i && bus.req_ready_o;
    assign idx             = bus.req_addr_i[DEPTH_LOG2+1:2];

    // Size 11 behaves as a word; sub-word stores replicate data so each lane sees its slice.
    always_comb begin
        eff_size    = (bus.req_size_i == 2'b11) ? 2'b10 : bus.req_size_i;
        lane        = 2'b00;
        be          = 4'b1111;
        wdata_lanes = bus.req_wdata_i[31:0];
        case (eff_size)
            2'b00: begin
                lane        = bus.req_addr_i[1:0];
                be          = 4'b0001 << bus.req_addr_i[1:0];
                wdata_lanes = {4{bus.req_wdata_i[7:0]}};
            end
            2'b01: begin
                lane        = {bus.req_addr_i[1], 1'b0};
                be          = bus.req_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{bus.req_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef CORE_DMEM_ERR_CHK_EN
    always_comb begin
        fault = (bus.req_size_i == 2'b11)
             || (bus.req_size_i == 2'b01 && bus.req_addr_i[0])
             || (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] != 2'b00)
             || ((bus.req_addr_i >> (DEPTH_LOG2 + 2)) != '0);
    end
`else
    // Upper address bits are ignored so accesses wrap within the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr_i[XLEN-1:DEPTH_LOG2+2];
    assign fault = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (accept) begin
                    if (bus.req_we_i && !fault && be[gi])
                        mem[idx] <= wdata_lanes[gi*8 +: 8];
                    rd_byte_reg <= mem[idx];
                end
            end

            assign rd_word[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg    <= 1'b0;
            rsp_err_reg      <= 1'b0;
            rsp_load_reg     <= 1'b0;
            rsp_size_reg     <= 2'b00;
            rsp_lane_reg     <= 2'b00;
            rsp_unsigned_reg <= 1'b0;
        end else if (accept) begin
            rsp_valid_reg    <= 1'b1;
            rsp_err_reg      <= fault;
            rsp_load_reg     <= !bus.req_we_i;
            rsp_size_reg     <= eff_size;
            rsp_lane_reg     <= lane;
            rsp_unsigned_reg <= bus.req_unsigned_i;
        end else if (bus.rsp_ready_i) begin
            rsp_valid_reg    <= 1'b0;
        end
    end

    // Read register only changes on acceptance, so the extended result stays stable while stalled.
    always_comb begin
        shifted = rd_word >> {rsp_lane_reg, 3'b000};
        case (rsp_size_reg)
            2'b00:   load_data = {{(XLEN-8){!rsp_unsigned_reg && shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{(XLEN-16){!rsp_unsigned_reg && shifted[15]}}, shifted[15:0]};
            default: load_data = rd_word;
        endcase
    end

    assign bus.rsp_valid_o = rsp_valid_reg;
    assign bus.rsp_err_o   = rsp_valid_reg && rsp_err_reg;
    assign bus.rsp_rdata_o = (rsp_valid_reg && rsp_load_reg && !rsp_err_reg) ? load_data : '0;

endmodule

// File: tb/tb_core_dmem.sv
// Randomized bench for core_dmem against a byte-addressed reference memory model.
`ifndef CPU_XLEN
`define CPU_XLEN 32
`endif

module tb_core_dmem;
    localparam int DEPTH_LOG2 = 10;
    localparam int NBYTES     = 4 << DEPTH_LOG2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_dmem_if bus();

    core_dmem #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  ref_mem [NBYTES];
    logic        pend     = 1'b0;
    logic [31:0] pend_data;
    logic        pend_err;
    string       pend_tag;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural model: memory is a flat byte array, accesses are byte ranges.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns,
                         output logic [31:0] data, output logic err);
        int n;
        int base;
        logic [31:0] v;
        n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        data = 32'd0;
        err  = 1'b0;
`ifdef CORE_DMEM_ERR_CHK_EN
        err  = (size == 2'd3) || (addr % n != 0) || (addr >= NBYTES);
        base = int'(addr % NBYTES);
`else
        base = int'(addr % NBYTES);
        base = base - (base % n);
`endif
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[base + i] = wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8*i));
                if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
                data = v;
            end
        end
    endtask

    task automatic check_pending();
        if (pend) begin
            check({pend_tag, "_valid"}, 32'(bus.rsp_valid_o), 32'd1);
            check({pend_tag, "_rdata"}, bus.rsp_rdata_o, pend_data);
            check({pend_tag, "_err"}, 32'(bus.rsp_err_o), 32'(pend_err));
            pend = 1'b0;
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wdata;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
    endtask

    // Back-to-back issue: the previous response is checked on the same cycle the next request is accepted.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input string tag);
        @(negedge clk);
        check_pending();
        drive(we, addr, wdata, size, uns);
        bus.rsp_ready_i = 1'b1;
        #1;
        check({tag, "_ready"}, 32'(bus.req_ready_o), 32'd1);
        @(posedge clk);
        model(we, addr, wdata, size, uns, pend_data, pend_err);
        pend     = 1'b1;
        pend_tag = tag;
        $display("TXN %s %s size=%0d addr=%h wdata=%h uns=%0b exp=%h err=%0b",
                 tag, we ? "ST" : "LD", size, addr, wdata, uns, pend_data, pend_err);
    endtask

    task automatic idle();
        @(negedge clk);
        check_pending();
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("idle_valid", 32'(bus.rsp_valid_o), 32'd0);
    endtask

    logic [31:0] exp_d;
    logic        exp_e;

    initial begin
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_addr_i     = '0;
        bus.req_wdata_i    = '0;
        bus.req_size_i     = 2'd0;
        bus.req_unsigned_i = 1'b0;
        bus.rsp_ready_i    = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_rdata", bus.rsp_rdata_o, 32'd0);
        check("rst_err", 32'(bus.rsp_err_o), 32'd0);
        check("rst_ready", 32'(bus.req_ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill the first 256 bytes so every later load reads defined data.
        for (int w = 0; w < 64; w++) issue(1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, "init");

        issue(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, "st_beef");
        issue(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, "ld_beef");
        check("ld_beef_const", pend_data, 32'hDEADBEEF);

        issue(1'b1, 32'h10, 32'h11223344, 2'd2, 1'b0, "st_base");
        issue(1'b1, 32'h13, 32'h00000080, 2'd0, 1'b0, "st_b80");
        issue(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, "ld_bs");
        check("ld_bs_const", pend_data, 32'hFFFFFF80);
        issue(1'b0, 32'h13, 32'h0, 2'd0, 1'b1, "ld_bu");
        check("ld_bu_const", pend_data, 32'h00000080);
        issue(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, "ld_w80");
        check("ld_w80_const", pend_data, 32'h80223344);

        issue(1'b1, 32'h20, 32'h55667788, 2'd2, 1'b0, "st_prior");
        issue(1'b1, 32'h21, 32'h0000AAAA, 2'd1, 1'b0, "st_h_odd");
        issue(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, "ld_prior");
        idle();

        // Response stall: held output, blocked request, acceptance only once rsp_ready_i rises.
        @(negedge clk);
        drive(1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
        bus.rsp_ready_i = 1'b0;
        @(posedge clk);
        model(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, exp_d, exp_e);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.rsp_valid_o), 32'd1);
            check("stall_rdata", bus.rsp_rdata_o, exp_d);
            check("stall_ready", 32'(bus.req_ready_o), 32'd0);
            drive(1'b1, 32'h10, 32'hCAFEF00D, 2'd2, 1'b0);
            @(posedge clk);
        end
        @(negedge clk);
        check("stall_end_rdata", bus.rsp_rdata_o, exp_d);
        bus.rsp_ready_i = 1'b1;
        #1;
        check("stall_release_ready", 32'(bus.req_ready_o), 32'd1);
        @(posedge clk);
        model(1'b1, 32'h10, 32'hCAFEF00D, 2'd2, 1'b0, pend_data, pend_err);
        pend     = 1'b1;
        pend_tag = "st_after_stall";
        $display("TXN st_after_stall ST size=2 addr=00000010 wdata=cafef00d");
        issue(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, "ld_after_stall");

        // Reset while a response is pending.
        issue(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, "ld_pre_rst");
        @(negedge clk);
        check_pending();
        bus.req_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("midrst_rdata", bus.rsp_rdata_o, 32'd0);
        check("midrst_err", 32'(bus.rsp_err_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_ready", 32'(bus.req_ready_o), 32'd1);
        check("postrst_valid", 32'(bus.rsp_valid_o), 32'd0);
        issue(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, "ld_post_rst");
        issue(1'b0, 32'h13, 32'h0, 2'd0, 1'b1, "ld_post_rst_b");

        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) a = a | (32'h1000 << $urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) idle();
            issue(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), "rnd");
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/core_dmem.md
CORE_DMEM -- requirements
Module: core_dmem

Interface
- REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of the word count of the data array (1024 words = 4 KiB).
- REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
- REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
- REQ-004 SHALL have port req_valid_i, input, 1, load/store request from the MEM stage is valid.
- REQ-005 SHALL have port req_ready_o, output, 1, block accepts the request this cycle.
- REQ-006 SHALL have port req_we_i, input, 1, 1 = store, 0 = load.
- REQ-007 SHALL have port req_addr_i, input, `CPU_XLEN, byte address.
- REQ-008 SHALL have port req_wdata_i, input, `CPU_XLEN, store data, right-aligned.
- REQ-009 SHALL have port req_size_i, input, 2, 00 byte, 01 half, 10 word, 11 reserved.
- REQ-010 SHALL have port req_unsigned_i, input, 1, 1 = zero-extend loads, 0 = sign-extend.
- REQ-011 SHALL have port rsp_valid_o, output, 1, response valid.
- REQ-012 SHALL have port rsp_ready_i, input, 1, MEM stage consumes the response.
- REQ-013 SHALL have port rsp_rdata_o, output, `CPU_XLEN, extended load data; 0 for stores and errors.
- REQ-014 SHALL have port rsp_err_o, output, 1, access fault (misaligned, out of range, reserved size).

Function
- REQ-015 SHALL accept a request on a rising edge where req_valid_i & req_ready_o.
- REQ-016 SHALL drive req_ready_o = !rsp_valid_o | rsp_ready_i (one outstanding response, full throughput of one request per cycle).
- REQ-017 SHALL assert rsp_valid_o on the cycle after acceptance (latency 1) and hold rsp_valid_o, rsp_rdata_o and rsp_err_o stable while rsp_valid_o & !rsp_ready_i.
- REQ-018 SHALL deassert rsp_valid_o after a cycle with rsp_valid_o & rsp_ready_i and no new acceptance; a simultaneous acceptance SHALL load the new response instead.
- REQ-019 SHALL index the array with req_addr_i[DEPTH_LOG2+1:2] and select lanes with req_addr_i[1:0].
- REQ-020 SHALL write only the addressed byte lanes on an accepted, non-faulting store: byte writes wdata[7:0] to lane addr[1:0], half writes wdata[15:0] to lanes addr[1]*2..+1, word writes all four.
- REQ-021 SHALL return for loads the addressed byte/half shifted to bit 0, sign- or zero-extended per req_unsigned_i; word loads return the full word.
- REQ-022 SHALL make a store visible to a load accepted on any later edge, including the immediately following one.
- REQ-023 SHALL leave the array unmodified by any faulting access.

Reset
- REQ-024 SHALL, while rst_n is low, force rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0 regardless of clk.
- REQ-025 SHALL discard any pending response on reset mid-operation; req_ready_o = 1 on the first cycle after release.
- REQ-026 SHALL NOT reset array contents.

Configuration
- REQ-027 SHALL, with CORE_DMEM_ERR_CHK_EN defined, flag rsp_err_o = 1 for half at odd address, word at addr[1:0] != 0, size 11, or any address bit above DEPTH_LOG2+1 set.
- REQ-028 SHALL, without CORE_DMEM_ERR_CHK_EN, tie rsp_err_o to 0, align half/word addresses down, treat size 11 as word, and ignore upper address bits (wrap modulo array size).

Verification
- REQ-029 SHALL cover: store word 0xDEADBEEF @0x10, then load word @0x10 next cycle -> rsp_rdata_o = 0xDEADBEEF one cycle after acceptance, rsp_err_o = 0.
- REQ-030 SHALL cover: store byte 0x80 @0x13 over 0x11223344, load byte signed @0x13 -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load word -> 0x80223344.
- REQ-031 SHALL cover: load with rsp_ready_i = 0 for 3 cycles -> rsp_valid_o and data held stable, req_ready_o = 0, second request accepted only on the cycle rsp_ready_i = 1.
- REQ-032 SHALL cover: with CORE_DMEM_ERR_CHK_EN, store half 0xAAAA @0x21 -> rsp_err_o = 1, rsp_rdata_o = 0, subsequent load word @0x20 returns prior contents.
- REQ-033 SHALL cover: rst_n low while rsp_valid_o = 1 -> rsp_valid_o = 0 immediately, earlier stored data still readable after release.
